// File: rtl/eth_frame_rx.sv
// eth_frame_rx: receive-side Ethernet header deframer.
// Strips the 14-byte header (dest MAC, src MAC, EtherType) from an 8-bit
// AXI-Stream frame, presents it on a valid/ready header port and forwards
// the remaining bytes through a single-register payload stream.
`timescale 1ns/1ps
module eth_frame_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_eth_hdr_valid,
    input  logic        m_eth_hdr_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [7:0]  m_eth_payload_axis_tdata,
    output logic        m_eth_payload_axis_tkeep,
    output logic        m_eth_payload_axis_tvalid,
    input  logic        m_eth_payload_axis_tready,
    output logic        m_eth_payload_axis_tlast,
    output logic        m_eth_payload_axis_tuser,
    output logic        busy,
    output logic        error_header_early_termination
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  hdr_ptr_reg, hdr_ptr_next;

    // Header bytes 0..12 live in the shadow; byte 13 is taken straight from
    // the input on the beat that completes the header.
    logic [103:0] shadow_flat;

    logic        hdr_valid_reg;
    logic [47:0] dest_mac_reg;
    logic [47:0] src_mac_reg;
    logic [15:0] eth_type_reg;

    logic [7:0]  pay_tdata_reg;
    logic        pay_tvalid_reg;
    logic        pay_tlast_reg;
    logic        pay_tuser_reg;

    logic        err_reg;

    logic        tready_int;
    logic        s_accept;
    logic        hdr_wr;
    logic        hdr_load;
    logic        hdr_err;
    logic        pay_load;

    // Input ready depends on the state; forced low while reset is asserted.
    always_comb begin
        tready_int = 1'b0;
        case (state_reg)
            IDLE:    tready_int = !hdr_valid_reg;
            HDR:     tready_int = 1'b1;
            PAYLOAD: tready_int = m_eth_payload_axis_tready || !pay_tvalid_reg;
            default: tready_int = 1'b0;
        endcase
    end

    assign s_axis_tready = tready_int && !rst;
    assign s_accept      = s_axis_tvalid && s_axis_tready;

    // Next-state, header pointer and datapath strobes.
    always_comb begin
        state_next   = state_reg;
        hdr_ptr_next = hdr_ptr_reg;
        hdr_wr       = 1'b0;
        hdr_load     = 1'b0;
        hdr_err      = 1'b0;
        pay_load     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_accept) begin
                    hdr_wr = 1'b1;
                    if (s_axis_tlast) begin
                        hdr_err      = 1'b1;
                        hdr_ptr_next = 4'd0;
                    end else begin
                        state_next   = HDR;
                        hdr_ptr_next = 4'd1;
                    end
                end
            end
            HDR: begin
                if (s_accept) begin
                    hdr_wr = 1'b1;
                    if (s_axis_tlast) begin
                        hdr_err      = 1'b1;
                        state_next   = IDLE;
                        hdr_ptr_next = 4'd0;
                    end else if (hdr_ptr_reg == 4'd13) begin
                        hdr_load     = 1'b1;
                        state_next   = PAYLOAD;
                        hdr_ptr_next = 4'd0;
                    end else begin
                        hdr_ptr_next = hdr_ptr_reg + 4'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (s_accept) begin
                    pay_load = 1'b1;
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                hdr_ptr_next = 4'd0;
            end
        endcase
    end

    // State and header pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            hdr_ptr_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            hdr_ptr_reg <= hdr_ptr_next;
        end
    end

    // One shadow byte per header position 0..12, written when the pointer matches.
    generate
        for (genvar gi = 0; gi < 13; gi++) begin : g_shadow
            logic [7:0] byte_reg;

            // Capture the accepted header byte at this position.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_reg <= 8'd0;
                end else if (hdr_wr && (hdr_ptr_reg == 4'(gi))) begin
                    byte_reg <= s_axis_tdata;
                end
            end

            assign shadow_flat[103 - 8*gi -: 8] = byte_reg;
        end
    endgenerate

    // Header output register: loaded on byte 13, held until consumed, then cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_valid_reg <= 1'b0;
            dest_mac_reg  <= 48'd0;
            src_mac_reg   <= 48'd0;
            eth_type_reg  <= 16'd0;
        end else if (hdr_load) begin
            hdr_valid_reg <= 1'b1;
            dest_mac_reg  <= shadow_flat[103:56];
            src_mac_reg   <= shadow_flat[55:8];
            eth_type_reg  <= {shadow_flat[7:0], s_axis_tdata};
        end else if (hdr_valid_reg && m_eth_hdr_ready) begin
            hdr_valid_reg <= 1'b0;
            dest_mac_reg  <= 48'd0;
            src_mac_reg   <= 48'd0;
            eth_type_reg  <= 16'd0;
        end
    end

    // Payload output register: load on accept, drop valid once the sink takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pay_tvalid_reg <= 1'b0;
            pay_tdata_reg  <= 8'd0;
            pay_tlast_reg  <= 1'b0;
            pay_tuser_reg  <= 1'b0;
        end else if (pay_load) begin
            pay_tvalid_reg <= 1'b1;
            pay_tdata_reg  <= s_axis_tdata;
            pay_tlast_reg  <= s_axis_tlast;
            pay_tuser_reg  <= s_axis_tlast && s_axis_tuser;
        end else if (m_eth_payload_axis_tready) begin
            pay_tvalid_reg <= 1'b0;
        end
    end

    // One-cycle pulse after a header byte carrying tlast is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= hdr_err;
        end
    end

    assign m_eth_hdr_valid                = hdr_valid_reg;
    assign m_eth_dest_mac                 = dest_mac_reg;
    assign m_eth_src_mac                  = src_mac_reg;
    assign m_eth_type                     = eth_type_reg;
    assign m_eth_payload_axis_tdata       = pay_tdata_reg;
    assign m_eth_payload_axis_tkeep       = pay_tvalid_reg;
    assign m_eth_payload_axis_tvalid      = pay_tvalid_reg;
    assign m_eth_payload_axis_tlast       = pay_tlast_reg;
    assign m_eth_payload_axis_tuser       = pay_tuser_reg;
    assign busy                           = (state_reg != IDLE);
    assign error_header_early_termination = err_reg;

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed testbench for eth_frame_rx: header extraction, payload forwarding,
// backpressure on both outputs, early termination, tuser and mid-frame reset.
`timescale 1ns/1ps
module tb_eth_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  p_tdata;
    logic        p_tkeep;
    logic        p_tvalid;
    logic        p_tready = 1'b1;
    logic        p_tlast;
    logic        p_tuser;
    logic        busy;
    logic        err;

    eth_frame_rx dut (
        .clk                            (clk),
        .rst                            (rst),
        .s_axis_tdata                   (s_tdata),
        .s_axis_tvalid                  (s_tvalid),
        .s_axis_tready                  (s_tready),
        .s_axis_tlast                   (s_tlast),
        .s_axis_tuser                   (s_tuser),
        .m_eth_hdr_valid                (hdr_valid),
        .m_eth_hdr_ready                (hdr_ready),
        .m_eth_dest_mac                 (dest_mac),
        .m_eth_src_mac                  (src_mac),
        .m_eth_type                     (eth_type),
        .m_eth_payload_axis_tdata       (p_tdata),
        .m_eth_payload_axis_tkeep       (p_tkeep),
        .m_eth_payload_axis_tvalid      (p_tvalid),
        .m_eth_payload_axis_tready      (p_tready),
        .m_eth_payload_axis_tlast       (p_tlast),
        .m_eth_payload_axis_tuser       (p_tuser),
        .busy                           (busy),
        .error_header_early_termination (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor state
    logic [7:0]   pay_data_q[$];
    logic         pay_last_q[$];
    logic         pay_user_q[$];
    logic [111:0] hdr_q[$];
    int err_cnt = 0;
    int err_cyc = 0;
    int hdr_rise_cnt = 0;
    int hdr_rise_cyc = 0;
    int pay_rise_cyc = -1;
    int stab_viol = 0;
    int stall_cnt = 0;
    bit pay_toggle = 1'b0;

    // Driver state
    logic [7:0] tx_q[$];
    int         acc_cyc[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Toggle payload ready every cycle when requested.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pay_toggle) p_tready = ~p_tready;
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        logic       hdr_valid_prev;
        logic       pay_valid_prev;
        logic       pay_stall_prev;
        logic [9:0] pay_prev;
        hdr_valid_prev = 1'b0;
        pay_valid_prev = 1'b0;
        pay_stall_prev = 1'b0;
        pay_prev = 10'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hdr_valid_prev = 1'b0;
                pay_valid_prev = 1'b0;
                pay_stall_prev = 1'b0;
            end else begin
                if (p_tvalid && p_tready) begin
                    pay_data_q.push_back(p_tdata);
                    pay_last_q.push_back(p_tlast);
                    pay_user_q.push_back(p_tuser);
                end
                if (pay_stall_prev && (!p_tvalid || ({p_tdata, p_tlast, p_tuser} !== pay_prev)))
                    stab_viol++;
                pay_stall_prev = p_tvalid && !p_tready;
                pay_prev = {p_tdata, p_tlast, p_tuser};
                if (p_tvalid && !pay_valid_prev && pay_rise_cyc < 0) pay_rise_cyc = cyc;
                pay_valid_prev = p_tvalid;
                if (hdr_valid && hdr_ready) hdr_q.push_back({dest_mac, src_mac, eth_type});
                if (hdr_valid && !hdr_valid_prev) begin
                    hdr_rise_cnt++;
                    hdr_rise_cyc = cyc;
                end
                hdr_valid_prev = hdr_valid;
                if (err) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        pay_data_q.delete();
        pay_last_q.delete();
        pay_user_q.delete();
        hdr_q.delete();
        err_cnt = 0;
        hdr_rise_cnt = 0;
        pay_rise_cyc = -1;
        stab_viol = 0;
        stall_cnt = 0;
    endtask

    task automatic build_frame(input logic [47:0] d, input logic [47:0] s,
                               input logic [15:0] t, input int plen, input logic [7:0] seed);
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) tx_q.push_back(s[47-8*i -: 8]);
        tx_q.push_back(t[15:8]);
        tx_q.push_back(t[7:0]);
        for (int i = 0; i < plen; i++) tx_q.push_back(seed + 8'(i));
    endtask

    // Present tx_q as one frame; stop before byte abort_at when abort_at >= 0.
    task automatic send_frame(input logic tuser_last, input int abort_at);
        int idx;
        int budget;
        idx = 0;
        budget = 0;
        acc_cyc.delete();
        while (idx < tx_q.size()) begin
            if (idx == abort_at) break;
            s_tdata  = tx_q[idx];
            s_tvalid = 1'b1;
            s_tlast  = (idx == tx_q.size() - 1);
            s_tuser  = (idx == tx_q.size() - 1) && tuser_last;
            @(negedge clk);
            if (s_tready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end else begin
                stall_cnt++;
            end
            budget++;
            @(posedge clk);
            #1;
            if (budget > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_frame_timeout: accepted %0d of %0d bytes", idx, tx_q.size());
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        $display("tx frame: len=%0d accepted=%0d", tx_q.size(), idx);
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {hdr_valid, dest_mac, src_mac, eth_type, p_tvalid, p_tdata, p_tkeep,
                p_tlast, p_tuser, busy, err, s_tready};
        n_checks++;
        if (outs !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_tready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release_idle: got tready/busy %b expected 10", {s_tready, busy});
        end
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_arp();
        logic [223:0] arp;
        logic [111:0] exp_hdr;
        arp = 224'h0001_0800_0604_0001_5A5152535455_C0A80164_000000000000_C0A80165;
        exp_hdr = {48'hFFFFFFFFFFFF, 48'h5A5152535455, 16'h0806};
        clear_mon();
        build_frame(48'hFFFFFFFFFFFF, 48'h5A5152535455, 16'h0806, 0, 8'h00);
        for (int i = 0; i < 28; i++) tx_q.push_back(arp[223-8*i -: 8]);
        send_frame(1'b0, -1);
        idle_cycles(5);
        n_checks++;
        if (stall_cnt !== 0) begin
            n_fail++;
            $display("FAIL arp_input_stalls: got %0d expected 0", stall_cnt);
        end
        n_checks++;
        if (acc_cyc.size() != 42 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 41) begin
            n_fail++;
            $display("FAIL arp_input_cycles: got %0d bytes expected 42 in 42 cycles", acc_cyc.size());
        end
        n_checks++;
        if (hdr_q.size() != 1 || hdr_q[0] !== exp_hdr) begin
            n_fail++;
            $display("FAIL arp_header: got %0d hdrs first %h expected %h", hdr_q.size(), hdr_q[0], exp_hdr);
        end
        n_checks++;
        if (acc_cyc.size() == 42 && hdr_rise_cyc != acc_cyc[13] + 1) begin
            n_fail++;
            $display("FAIL arp_hdr_latency: got cycle %0d expected %0d", hdr_rise_cyc, acc_cyc[13] + 1);
        end
        n_checks++;
        if (acc_cyc.size() == 42 && pay_rise_cyc != acc_cyc[14] + 1) begin
            n_fail++;
            $display("FAIL arp_pay_latency: got cycle %0d expected %0d", pay_rise_cyc, acc_cyc[14] + 1);
        end
        n_checks++;
        if (pay_data_q.size() != 28) begin
            n_fail++;
            $display("FAIL arp_pay_count: got %0d expected 28", pay_data_q.size());
        end
        for (int i = 0; i < 28 && i < pay_data_q.size(); i++) begin
            n_checks++;
            if (pay_data_q[i] !== tx_q[14+i] || pay_last_q[i] !== (i == 27)) begin
                n_fail++;
                $display("FAIL arp_pay_beat%0d: got %h/%b expected %h/%b",
                         i, pay_data_q[i], pay_last_q[i], tx_q[14+i], (i == 27));
            end
        end
        n_checks++;
        if (err_cnt !== 0) begin
            n_fail++;
            $display("FAIL arp_no_error: got %0d pulses expected 0", err_cnt);
        end
        $display("test_arp done: %0d payload beats", pay_data_q.size());
    endtask

    task automatic test_hdr_backpressure();
        logic [111:0] hdr_a;
        logic [111:0] hdr_b;
        int hold_viol;
        int tr_viol;
        hdr_a = {48'h020000000001, 48'h02000000000A, 16'h0800};
        hdr_b = {48'h0A0B0C0D0E0F, 48'h101112131415, 16'h86DD};
        hold_viol = 0;
        tr_viol = 0;
        clear_mon();
        hdr_ready = 1'b0;
        build_frame(48'h020000000001, 48'h02000000000A, 16'h0800, 4, 8'h10);
        send_frame(1'b0, -1);
        build_frame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h86DD, 3, 8'h40);
        fork
            send_frame(1'b0, -1);
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (!hdr_valid || {dest_mac, src_mac, eth_type} !== hdr_a) hold_viol++;
                    if (s_tready) tr_viol++;
                end
                @(posedge clk);
                #1;
                hdr_ready = 1'b1;
            end
        join
        idle_cycles(5);
        n_checks++;
        if (hold_viol !== 0) begin
            n_fail++;
            $display("FAIL hdr_hold_stable: got %0d unstable cycles expected 0", hold_viol);
        end
        n_checks++;
        if (tr_viol !== 0) begin
            n_fail++;
            $display("FAIL hdr_idle_stall: got %0d ready cycles expected 0", tr_viol);
        end
        n_checks++;
        if (hdr_q.size() != 2 || hdr_q[0] !== hdr_a || hdr_q[1] !== hdr_b) begin
            n_fail++;
            $display("FAIL hdr_bp_headers: got %0d hdrs %h %h expected %h %h",
                     hdr_q.size(), hdr_q[0], hdr_q[1], hdr_a, hdr_b);
        end
        n_checks++;
        if (pay_data_q.size() != 7 || pay_data_q[0] !== 8'h10 || pay_data_q[3] !== 8'h13 ||
            pay_data_q[4] !== 8'h40 || pay_data_q[6] !== 8'h42) begin
            n_fail++;
            $display("FAIL hdr_bp_payload: got %0d beats expected 7", pay_data_q.size());
        end
        n_checks++;
        if ({hdr_valid, dest_mac, src_mac, eth_type} !== 113'd0) begin
            n_fail++;
            $display("FAIL hdr_cleared: got %h expected 0", {hdr_valid, dest_mac, src_mac, eth_type});
        end
        $display("test_hdr_backpressure done: %0d headers", hdr_q.size());
    endtask

    task automatic test_payload_backpressure();
        clear_mon();
        pay_toggle = 1'b1;
        build_frame(48'h001122334455, 48'h66778899AABB, 16'h88B5, 60, 8'h80);
        send_frame(1'b0, -1);
        idle_cycles(4);
        pay_toggle = 1'b0;
        p_tready = 1'b1;
        idle_cycles(3);
        n_checks++;
        if (pay_data_q.size() != 60) begin
            n_fail++;
            $display("FAIL pbp_count: got %0d expected 60", pay_data_q.size());
        end
        for (int i = 0; i < 60 && i < pay_data_q.size(); i++) begin
            n_checks++;
            if (pay_data_q[i] !== tx_q[14+i] || pay_last_q[i] !== (i == 59)) begin
                n_fail++;
                $display("FAIL pbp_beat%0d: got %h/%b expected %h/%b",
                         i, pay_data_q[i], pay_last_q[i], tx_q[14+i], (i == 59));
            end
        end
        n_checks++;
        if (stab_viol !== 0) begin
            n_fail++;
            $display("FAIL pbp_stable: got %0d violations expected 0", stab_viol);
        end
        n_checks++;
        if (hdr_q.size() != 1) begin
            n_fail++;
            $display("FAIL pbp_header: got %0d expected 1", hdr_q.size());
        end
        $display("test_payload_backpressure done: %0d beats", pay_data_q.size());
    endtask

    task automatic test_early_term();
        logic [111:0] exp_hdr;
        exp_hdr = {48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h1234};
        clear_mon();
        build_frame(48'hDEADBEEF0001, 48'hCAFE00000002, 16'h0800, 0, 8'h00);
        while (tx_q.size() > 6) void'(tx_q.pop_back());
        send_frame(1'b0, -1);
        idle_cycles(3);
        n_checks++;
        if (err_cnt != 1 || acc_cyc.size() != 6 || err_cyc != acc_cyc[5] + 1) begin
            n_fail++;
            $display("FAIL early5_error: got %0d pulses at %0d expected 1 at %0d",
                     err_cnt, err_cyc, acc_cyc[5] + 1);
        end
        n_checks++;
        if (hdr_rise_cnt != 0 || pay_data_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early5_quiet: got hdr %0d pay %0d busy %b expected 0 0 0",
                     hdr_rise_cnt, pay_data_q.size(), busy);
        end
        build_frame(48'hDEADBEEF0003, 48'hCAFE00000004, 16'h0806, 0, 8'h00);
        send_frame(1'b0, -1);
        idle_cycles(3);
        n_checks++;
        if (err_cnt != 2 || acc_cyc.size() != 14 || err_cyc != acc_cyc[13] + 1) begin
            n_fail++;
            $display("FAIL early13_error: got %0d pulses at %0d expected 2 at %0d",
                     err_cnt, err_cyc, acc_cyc[13] + 1);
        end
        n_checks++;
        if (hdr_rise_cnt != 0 || pay_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL early13_quiet: got hdr %0d pay %0d expected 0 0",
                     hdr_rise_cnt, pay_data_q.size());
        end
        build_frame(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h1234, 5, 8'h20);
        send_frame(1'b0, -1);
        idle_cycles(3);
        n_checks++;
        if (hdr_q.size() != 1 || hdr_q[0] !== exp_hdr) begin
            n_fail++;
            $display("FAIL early_next_header: got %0d hdrs %h expected %h", hdr_q.size(), hdr_q[0], exp_hdr);
        end
        n_checks++;
        if (pay_data_q.size() != 5 || pay_data_q[0] !== 8'h20 || pay_data_q[4] !== 8'h24 ||
            pay_last_q[4] !== 1'b1 || err_cnt != 2) begin
            n_fail++;
            $display("FAIL early_next_payload: got %0d beats err %0d expected 5 beats err 2",
                     pay_data_q.size(), err_cnt);
        end
        $display("test_early_term done: %0d error pulses", err_cnt);
    endtask

    task automatic test_tuser();
        clear_mon();
        build_frame(48'h111111111111, 48'h222222222222, 16'h0800, 5, 8'h60);
        send_frame(1'b1, -1);
        idle_cycles(3);
        n_checks++;
        if (pay_data_q.size() != 5) begin
            n_fail++;
            $display("FAIL tuser_count: got %0d expected 5", pay_data_q.size());
        end
        for (int i = 0; i < 5 && i < pay_user_q.size(); i++) begin
            n_checks++;
            if (pay_user_q[i] !== (i == 4) || pay_data_q[i] !== 8'(8'h60 + i)) begin
                n_fail++;
                $display("FAIL tuser_beat%0d: got user %b data %h expected %b %h",
                         i, pay_user_q[i], pay_data_q[i], (i == 4), 8'(8'h60 + i));
            end
        end
        $display("test_tuser done");
    endtask

    task automatic test_back_to_back();
        int last_first;
        clear_mon();
        build_frame(48'h0000000000A1, 48'h0000000000B1, 16'h0800, 8, 8'h30);
        send_frame(1'b0, -1);
        last_first = acc_cyc[acc_cyc.size()-1];
        build_frame(48'h0000000000A2, 48'h0000000000B2, 16'h0806, 8, 8'h50);
        send_frame(1'b0, -1);
        idle_cycles(3);
        n_checks++;
        if (stall_cnt !== 0 || acc_cyc[0] != last_first + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d stalls start %0d expected 0 stalls start %0d",
                     stall_cnt, acc_cyc[0], last_first + 1);
        end
        n_checks++;
        if (hdr_q.size() != 2 || hdr_q[1][15:0] !== 16'h0806 || pay_data_q.size() != 16 ||
            pay_data_q[8] !== 8'h50 || pay_last_q[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_frames: got %0d hdrs %0d beats expected 2 hdrs 16 beats",
                     hdr_q.size(), pay_data_q.size());
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midframe();
        logic [127:0] outs;
        logic [111:0] exp_hdr;
        int snap_pay;
        int snap_hdr;
        int snap_err;
        exp_hdr = {48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0800};
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            build_frame(48'hE0E1E2E3E4E5, 48'hF0F1F2F3F4F5, 16'h0800, 20, 8'h70);
            send_frame(1'b0, (pass == 0) ? 8 : 24);
            rst = 1'b1;
            @(negedge clk);
            outs = {hdr_valid, dest_mac, src_mac, eth_type, p_tvalid, p_tdata, p_tkeep,
                    p_tlast, p_tuser, busy, err, s_tready};
            n_checks++;
            if (outs !== 128'd0) begin
                n_fail++;
                $display("FAIL midreset%0d_outputs: got %h expected 0", pass, outs);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
            snap_pay = pay_data_q.size();
            snap_hdr = hdr_rise_cnt;
            snap_err = err_cnt;
            idle_cycles(10);
            n_checks++;
            if (pay_data_q.size() != snap_pay || hdr_rise_cnt != snap_hdr ||
                err_cnt != snap_err || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset%0d_quiet: got pay %0d hdr %0d err %0d busy %b expected %0d %0d %0d 0",
                         pass, pay_data_q.size(), hdr_rise_cnt, err_cnt, busy, snap_pay, snap_hdr, snap_err);
            end
        end
        clear_mon();
        build_frame(48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0800, 6, 8'h90);
        send_frame(1'b0, -1);
        idle_cycles(3);
        n_checks++;
        if (hdr_q.size() != 1 || hdr_q[0] !== exp_hdr || pay_data_q.size() != 6 ||
            pay_data_q[0] !== 8'h90 || pay_data_q[5] !== 8'h95 || pay_last_q[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_next_frame: got %0d hdrs %h %0d beats expected 1 %h 6 beats",
                     hdr_q.size(), hdr_q[0], pay_data_q.size(), exp_hdr);
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_arp();
        test_hdr_backpressure();
        test_payload_backpressure();
        test_early_term();
        test_tuser();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_frame_rx.md
# eth_frame_rx

Receive-side Ethernet header deframer with an 8-bit AXI-Stream input. It takes raw frames from the MAC/FIFO, strips and registers the 14-byte Ethernet header (destination MAC, source MAC, EtherType), and forwards the remaining bytes as a payload stream. It sits directly upstream of the ARP block and drives its `s_eth_hdr_*` and `s_eth_payload_axis_*` inputs.

## Interface
- No parameters. Data width is fixed at 8 bits; tkeep is 1 bit.
- `clk` in 1: clock, all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `s_axis_tdata` in 8: frame byte; byte 0 is the first destination-MAC octet.
- `s_axis_tvalid` in 1: input byte valid.
- `s_axis_tready` out 1: input byte accepted on tvalid&tready.
- `s_axis_tlast` in 1: last byte of the frame.
- `s_axis_tuser` in 1: frame error flag, sampled on the tlast beat.
- `m_eth_hdr_valid` out 1: header fields valid.
- `m_eth_hdr_ready` in 1: header consumed.
- `m_eth_dest_mac` out 48: bytes 0..5; byte 0 maps to [47:40].
- `m_eth_src_mac` out 48: bytes 6..11; byte 6 maps to [47:40].
- `m_eth_type` out 16: bytes 12..13; byte 12 maps to [15:8].
- `m_eth_payload_axis_tdata` out 8: payload byte (frame byte 14 onward).
- `m_eth_payload_axis_tkeep` out 1: constant 1 whenever tvalid is high.
- `m_eth_payload_axis_tvalid` out 1: payload byte valid.
- `m_eth_payload_axis_tready` in 1: payload byte accepted.
- `m_eth_payload_axis_tlast` out 1: last payload byte.
- `m_eth_payload_axis_tuser` out 1: copy of `s_axis_tuser` on the last beat.
- `busy` out 1: high while a frame is partially received (HDR or PAYLOAD state).
- `error_header_early_termination` out 1: one-cycle pulse.

## Operation
- State machine with states IDLE, HDR, PAYLOAD.
- A 4-bit header counter `hdr_ptr` counts 0..13 and tracks the next header byte index.
- IDLE:
  - `s_axis_tready = !m_eth_hdr_valid`.
  - An accepted byte is stored as dest[47:40], sets `hdr_ptr` to 1, and moves to HDR.
- HDR:
  - `s_axis_tready = 1`.
  - Each accepted byte is written into the header shadow register at `hdr_ptr`, and `hdr_ptr` increments.
  - When byte 13 is accepted without tlast: load the header outputs, set `m_eth_hdr_valid`, and go to PAYLOAD.
- Early termination: tlast on any header byte (0..13, including byte 13) means
  - `error_header_early_termination` pulses for one cycle;
  - `m_eth_hdr_valid` is not asserted;
  - the state returns to IDLE;
  - no payload beat is produced.
- PAYLOAD:
  - `s_axis_tready = m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid`, i.e. a single output register.
  - Each accepted byte is copied to the output register together with tlast and tuser.
  - Accepting the tlast byte moves the state to IDLE.
- Header output:
  - Held stable while `m_eth_hdr_valid && !m_eth_hdr_ready`.
  - Cleared on the cycle after the handshake.
  - The payload stream is not gated by the header handshake.
- A header from frame N+1 cannot overwrite frame N's header, because IDLE stalls input until the header is consumed.
- `busy` is high exactly in HDR and PAYLOAD.

## Timing
- Reset values: all tvalid and `m_eth_hdr_valid` are 0; all data, MAC and type outputs are 0; tlast, tuser, busy and error are 0; state is IDLE; `hdr_ptr` is 0. `s_axis_tready` is 0 during reset.
- Header latency: `m_eth_hdr_valid` rises on the clock edge that accepts byte 13, so it is visible the cycle after that byte is presented.
- Payload latency: 1 cycle from input acceptance to `m_eth_payload_axis_tvalid`.
- Throughput:
  - 1 byte/cycle with tready held high; no bubbles between header and payload.
  - Back-to-back frames: one bubble only if the header is still pending when the next frame starts.
- Error pulse: asserted the cycle after the tlast header byte is accepted, for exactly one cycle.
- Reset mid-frame: all state is discarded immediately and no partial header or payload is emitted after reset release.
- Output data is stable while valid is high and ready is low (AXIS rule).

## Test plan
- ARP frame: dest FF:FF:FF:FF:FF:FF, src 5A:51:52:53:54:55, type 0806, 28-byte ARP request payload, sink always ready.
  - Header: dest `48'hFFFFFFFFFFFF`, src `48'h5A5152535455`, type `16'h0806`.
  - Payload: 28 beats identical to input bytes 14..41, tlast only on beat 28, 42 input cycles with no stall.
- Header backpressure: `m_eth_hdr_ready` held 0 for 20 cycles, then a second frame is offered.
  - The first header stays stable.
  - `s_axis_tready` stays 0 in IDLE until the handshake, after which the second header is captured correctly.
- Payload backpressure: `m_eth_payload_axis_tready` toggles 1/0 every cycle on a 60-byte payload.
  - No byte is lost or duplicated.
  - tdata stays stable while stalled.
- Early termination: frames ending on byte 5 and on byte 13.
  - Error pulses once per frame.
  - No `m_eth_hdr_valid` and no payload beat.
  - The next good frame is parsed correctly.
- tuser: a frame with `s_axis_tuser=1` on its tlast byte produces `m_eth_payload_axis_tuser=1` on the last beat only.
- Reset mid-frame: `rst` asserted at header byte 8, then at payload byte 10.
  - All outputs return to reset values.
  - The following frame parses correctly.
